// File: rtl/writeback.sv
// rtl/writeback.sv - last pipeline stage: retires ALU results, waits for load data, flags load-use hazards
module writeback #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            req,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_rd,
    input  logic            ex_rd_write,
    input  logic [XLEN-1:0] ex_result,
    input  logic [2:0]      ex_funct3,
    input  logic [1:0]      ex_addr_lo,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [4:0]      rs1_in,
    input  logic            rs1_read_in,
    input  logic [4:0]      rs2_in,
    input  logic            rs2_read_in,
    output logic [4:0]      rd_out,
    output logic            rd_write_out,
    output logic [XLEN-1:0] rd_value_out,
    output logic            stall_out,
    output logic            hazard_out,
    output logic            err_out
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      prd_q, prd_d;
    logic            pwr_q, pwr_d;
    logic [2:0]      pf3_q, pf3_d;
    logic [1:0]      palo_q, palo_d;
    logic [4:0]      rd_q, rd_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] val_q, val_d;
    logic            err_q, err_d;

    logic            load_bad;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] aligned;

    // Misalignment and unsupported widths are rejected before any memory wait.
    always_comb begin
        load_bad = 1'b0;
        case (ex_funct3)
            3'b000, 3'b100: load_bad = 1'b0;
            3'b001, 3'b101: load_bad = ex_addr_lo[0];
            3'b010:         load_bad = (ex_addr_lo != 2'b00);
            default:        load_bad = 1'b1;
        endcase
    end

    always_comb begin
        byte_v  = 8'(mem_rdata >> {palo_q, 3'b000});
        half_v  = palo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        aligned = mem_rdata;
        case (pf3_q)
            3'b000:  aligned = {{(XLEN-8){byte_v[7]}}, byte_v};
            3'b100:  aligned = {{(XLEN-8){1'b0}}, byte_v};
            3'b001:  aligned = {{(XLEN-16){half_v[15]}}, half_v};
            3'b101:  aligned = {{(XLEN-16){1'b0}}, half_v};
            default: aligned = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prd_d   = prd_q;
        pwr_d   = pwr_q;
        pf3_d   = pf3_q;
        palo_d  = palo_q;
        rd_d    = rd_q;
        val_d   = val_q;
        we_d    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid && !ex_is_load) begin
                    rd_d  = ex_rd;
                    val_d = ex_result;
                    we_d  = ex_rd_write && (ex_rd != 5'd0);
                end else if (ex_valid) begin
                    if (load_bad) begin
                        err_d = 1'b1;
                    end else begin
                        prd_d   = ex_rd;
                        pwr_d   = ex_rd_write;
                        pf3_d   = ex_funct3;
                        palo_d  = ex_addr_lo;
                        cnt_d   = '0;
                        state_d = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                cnt_d = cnt_q + CW'(1);
                // A response arriving on the final cycle still wins over the timeout.
                if (mem_rvalid) begin
                    rd_d    = prd_q;
                    val_d   = aligned;
                    we_d    = pwr_q && (prd_q != 5'd0);
                    state_d = IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge req) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prd_q   <= 5'd0;
            pwr_q   <= 1'b0;
            pf3_q   <= 3'b000;
            palo_q  <= 2'b00;
            rd_q    <= 5'd0;
            we_q    <= 1'b0;
            val_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prd_q   <= prd_d;
            pwr_q   <= pwr_d;
            pf3_q   <= pf3_d;
            palo_q  <= palo_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            val_q   <= val_d;
            err_q   <= err_d;
        end
    end

    assign rd_out       = rd_q;
    assign rd_write_out = we_q;
    assign rd_value_out = val_q;
    assign err_out      = err_q;
    assign stall_out    = (state_q == WAIT_MEM);
    assign hazard_out   = (state_q == WAIT_MEM) && (prd_q != 5'd0) &&
                          ((rs1_read_in && (rs1_in == prd_q)) || (rs2_read_in && (rs2_in == prd_q)));
endmodule

// File: tb/tb_writeback.sv
// tb/tb_writeback.sv - randomized and directed bench for writeback against a transaction-level model
module tb_writeback;
    localparam int TMO = 16;

    logic        req, rst;
    logic        ex_valid, ex_is_load, ex_rd_write;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  rs1_in, rs2_in;
    logic        rs1_read_in, rs2_read_in;
    logic [4:0]  rd_out;
    logic        rd_write_out;
    logic [31:0] rd_value_out;
    logic        stall_out, hazard_out, err_out;

    writeback #(.XLEN(32), .TIMEOUT(TMO)) dut (
        .req(req), .rst(rst),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_rd_write(ex_rd_write),
        .ex_result(ex_result), .ex_funct3(ex_funct3), .ex_addr_lo(ex_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rs1_in(rs1_in), .rs1_read_in(rs1_read_in), .rs2_in(rs2_in), .rs2_read_in(rs2_read_in),
        .rd_out(rd_out), .rd_write_out(rd_write_out), .rd_value_out(rd_value_out),
        .stall_out(stall_out), .hazard_out(hazard_out), .err_out(err_out)
    );

    initial req = 1'b0;
    always #5 req = ~req;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // Transaction-level model: a pending load with an absolute deadline cycle.
    int          cyc = 0;
    int          m_deadline = 0;
    bit          m_busy = 1'b0;
    logic [4:0]  m_prd = 5'd0;
    bit          m_pwe = 1'b0;
    logic [2:0]  m_pf3 = 3'd0;
    logic [1:0]  m_palo = 2'd0;
    logic [4:0]  m_rd = 5'd0;
    logic [31:0] m_val = 32'd0;
    bit          m_we = 1'b0;
    bit          m_err = 1'b0;

    function automatic bit m_legal(input logic [2:0] f3, input logic [1:0] alo);
        int size;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        size = 1 << int'(f3[1:0]);
        return (int'(alo) % size) == 0;
    endfunction

    function automatic logic [31:0] m_align(input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * int'(alo))) & 32'h0000_00FF;
        h = (w >> (16 * int'(alo[1]))) & 32'h0000_FFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    always @(posedge req) begin
        cyc++;
        m_we  = 1'b0;
        m_err = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_rd = 5'd0; m_val = 32'd0; m_prd = 5'd0;
        end else if (!m_busy) begin
            if (ex_valid && !ex_is_load) begin
                m_rd = ex_rd; m_val = ex_result; m_we = ex_rd_write && (ex_rd != 5'd0);
            end else if (ex_valid) begin
                if (!m_legal(ex_funct3, ex_addr_lo)) m_err = 1'b1;
                else begin
                    m_busy = 1'b1; m_prd = ex_rd; m_pwe = ex_rd_write;
                    m_pf3 = ex_funct3; m_palo = ex_addr_lo; m_deadline = cyc + TMO;
                end
            end
        end else if (mem_rvalid) begin
            m_busy = 1'b0; m_rd = m_prd; m_val = m_align(m_pf3, m_palo, mem_rdata);
            m_we = m_pwe && (m_prd != 5'd0);
        end else if (cyc == m_deadline) begin
            m_busy = 1'b0; m_err = 1'b1;
        end
    end

    always @(negedge req) begin
        if (chk_en) begin
            bit hz;
            hz = m_busy && (m_prd != 5'd0) &&
                 ((rs1_read_in && rs1_in == m_prd) || (rs2_read_in && rs2_in == m_prd));
            chk("m_we",     32'(rd_write_out), 32'(m_we));
            chk("m_err",    32'(err_out),      32'(m_err));
            chk("m_stall",  32'(stall_out),    32'(m_busy));
            chk("m_hazard", 32'(hazard_out),   32'(hz));
            if (m_we) begin
                chk("m_rd",    32'(rd_out), 32'(m_rd));
                chk("m_value", rd_value_out, m_val);
            end
        end
    end

    task automatic step();
        @(posedge req);
        #1;
    endtask

    task automatic clr();
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; ex_rd_write = 1'b0; ex_result = 32'd0;
        ex_funct3 = 3'd0; ex_addr_lo = 2'd0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        rs1_in = 5'd0; rs2_in = 5'd0; rs1_read_in = 1'b0; rs2_read_in = 1'b0;
    endtask

    task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] alo);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = rd; ex_rd_write = 1'b1;
        ex_funct3 = f3; ex_addr_lo = alo; ex_result = 32'hBAD0_BAD0;
    endtask

    task automatic load_once(input string nm, input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] exp);
        issue_load(5'd4, f3, alo);
        step(); clr(); #1;
        chk({nm, "_stall"}, 32'(stall_out), 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0011;
        step(); clr(); #1;
        chk({nm, "_we"},    32'(rd_write_out), 32'd1);
        chk({nm, "_value"}, rd_value_out, exp);
    endtask

    initial begin
        int n;
        clr();
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_rd",     32'(rd_out),       32'd0);
        chk("rst_we",     32'(rd_write_out), 32'd0);
        chk("rst_value",  rd_value_out,      32'd0);
        chk("rst_err",    32'(err_out),      32'd0);
        chk("rst_stall",  32'(stall_out),    32'd0);
        rst = 1'b0;

        ex_valid = 1'b1; ex_rd = 5'd5; ex_rd_write = 1'b1; ex_result = 32'hDEAD_BEEF;
        step(); clr(); #1;
        chk("alu_we",    32'(rd_write_out), 32'd1);
        chk("alu_rd",    32'(rd_out),       32'd5);
        chk("alu_value", rd_value_out,      32'hDEAD_BEEF);
        step();
        chk("alu_we_drop", 32'(rd_write_out), 32'd0);

        ex_valid = 1'b1; ex_rd = 5'd0; ex_rd_write = 1'b1; ex_result = 32'h0000_1234;
        step(); clr(); #1;
        chk("rd0_we", 32'(rd_write_out), 32'd0);

        load_once("lb",  3'b000, 2'd3, 32'hFFFF_FF80);
        load_once("lbu", 3'b100, 2'd3, 32'h0000_0080);
        load_once("lh",  3'b001, 2'd2, 32'hFFFF_80FF);

        issue_load(5'd7, 3'b010, 2'd0);
        step(); clr();
        rs2_in = 5'd7; rs2_read_in = 1'b1; #1;
        chk("hz_stall1", 32'(stall_out),  32'd1);
        chk("hz_on",     32'(hazard_out), 32'd1);
        step();
        rs2_in = 5'd7; rs2_read_in = 1'b0; #1;
        chk("hz_stall2", 32'(stall_out),  32'd1);
        chk("hz_off",    32'(hazard_out), 32'd0);
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; #1;
        chk("hz_stall3", 32'(stall_out), 32'd1);
        step(); clr(); #1;
        chk("hz_stall_end", 32'(stall_out),    32'd0);
        chk("hz_we",        32'(rd_write_out), 32'd1);
        chk("hz_rd",        32'(rd_out),       32'd7);
        chk("hz_value",     rd_value_out,      32'h1234_5678);

        issue_load(5'd9, 3'b010, 2'd0);
        step(); clr();
        n = 0;
        while (stall_out && n < 40) begin
            n++;
            step();
        end
        chk("tmo_cycles", 32'(n),            32'd16);
        chk("tmo_err",    32'(err_out),      32'd1);
        chk("tmo_we",     32'(rd_write_out), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step(); clr(); #1;
        chk("tmo_err_drop", 32'(err_out),      32'd0);
        chk("tmo_late_we",  32'(rd_write_out), 32'd0);

        issue_load(5'd9, 3'b010, 2'd0);
        step(); clr();
        repeat (15) step();
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_CAFE; #1;
        chk("last_stall", 32'(stall_out), 32'd1);
        step(); clr(); #1;
        chk("last_we",    32'(rd_write_out), 32'd1);
        chk("last_err",   32'(err_out),      32'd0);
        chk("last_value", rd_value_out,      32'h0BAD_CAFE);

        issue_load(5'd6, 3'b010, 2'd1);
        step(); clr(); #1;
        chk("mis_err",   32'(err_out),      32'd1);
        chk("mis_stall", 32'(stall_out),    32'd0);
        chk("mis_we",    32'(rd_write_out), 32'd0);
        step();
        chk("mis_err_drop", 32'(err_out), 32'd0);

        issue_load(5'd3, 3'b010, 2'd0);
        step(); clr();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rs1_in = 5'd3; rs1_read_in = 1'b1; #1;
        chk("rstw_rd",     32'(rd_out),     32'd0);
        chk("rstw_value",  rd_value_out,    32'd0);
        chk("rstw_stall",  32'(stall_out),  32'd0);
        chk("rstw_hazard", 32'(hazard_out), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step(); clr(); #1;
        chk("rstw_late_we", 32'(rd_write_out), 32'd0);

        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            ex_valid    = ($urandom_range(0, 2) != 0);
            ex_is_load  = $urandom_range(0, 1) == 1;
            ex_rd       = 5'($urandom_range(0, 7));
            ex_rd_write = ($urandom_range(0, 5) != 0);
            ex_result   = $urandom;
            ex_funct3   = 3'($urandom_range(0, 7));
            ex_addr_lo  = 2'($urandom_range(0, 3));
            mem_rvalid  = m_busy ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 15) == 0);
            mem_rdata   = $urandom;
            rs1_in      = 5'($urandom_range(0, 7));
            rs2_in      = 5'($urandom_range(0, 7));
            rs1_read_in = $urandom_range(0, 1) == 1;
            rs2_read_in = $urandom_range(0, 1) == 1;
            step();
        end
        clr();
        rst = 1'b0;
        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
